// File: rtl/filter_core_pkg.sv
// Mode encodings, FSM state constants and per-mode coefficient tables
// shared by the multichannel FIR core and its coefficient ROM.
package filter_core_pkg;

  typedef enum logic [1:0] {
    MODE_BYP = 2'b00,
    MODE_LPF = 2'b01,
    MODE_HPF = 2'b10,
    MODE_BPF = 2'b11
  } mode_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_MAC   = 2'd2;
  localparam state_t ST_OUT   = 2'd3;

  // Q1.(cw-1) coefficients. BPF alternates sign on the mirrored tap index, so the
  // table is symmetric and rejects DC. Bypass never uses the MAC result.
  function automatic int coef_value(input mode_t mode, input int tap, input int taps, input int cw);
    int unit;
    int mirror;
    unit   = (1 << (cw - 1)) / taps;
    mirror = (tap < taps - 1 - tap) ? tap : taps - 1 - tap;
    case (mode)
      MODE_LPF: coef_value = unit;
      MODE_HPF: coef_value = (tap == 0) ? (1 << (cw - 1)) - 1 - unit : -unit;
      MODE_BPF: coef_value = (mirror % 2 == 1) ? -unit : unit;
      default:  coef_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/filter_core_mc_coef_rom.sv
// Combinational coefficient lookup by (mode, tap index) for filter_core_mc.
module filter_coef_rom
  import filter_core_pkg::*;
#(
  parameter int CW   = 16,
  parameter int TAPS = 16,
  parameter int TW   = 4
) (
  input  logic [1:0]           mode,
  input  logic [TW-1:0]        tap,
  output logic signed [CW-1:0] coef
);

  always_comb begin
    coef = CW'(coef_value(mode_t'(mode), int'(tap), TAPS, CW));
  end

endmodule

// File: rtl/filter_core_mc.sv
// Multichannel FIR core with one shared multiplier and selectable bypass/LPF/HPF/BPF.
// Define FILTER_CORE_SAT_EN to saturate results to DW bits instead of wrapping.
module filter_core_mc
  import filter_core_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int TAPS = 16,
  parameter int CH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_s,
  input  logic [1:0]       mode_sel,
  input  logic [CH*DW-1:0] din,
  input  logic             ovr_clr,
  output logic [CH*DW-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             overrun,
  output logic [1:0]       mode_act
);

  localparam int TW   = $clog2(TAPS);
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + TW;
  localparam logic signed [ACCW-1:0] RND = {{(ACCW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};
`ifdef FILTER_CORE_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  state_t                  state_reg, state_next;
  logic [TW-1:0]           tap_idx_reg;
  logic [CHW-1:0]          ch_idx_reg;
  logic [CH*DW-1:0]        din_cap_reg;
  logic [1:0]              mode_cap_reg, mode_act_reg;
  logic signed [ACCW-1:0]  acc_reg;
  logic                    dout_valid_reg, overrun_reg;

  logic                    accept, last_tap, last_ch, mac_last, mac_final, mode_change;
  logic [CH*DW-1:0]        sample_flat, newest_flat;
  logic signed [DW-1:0]    cur_sample;
  logic [DW-1:0]           cur_newest;
  logic signed [CW-1:0]    coef;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc_base, acc_sum;
  logic [DW-1:0]           result;

  assign accept      = (state_reg == ST_IDLE) && f_s;
  assign last_tap    = tap_idx_reg == TW'(TAPS - 1);
  assign last_ch     = ch_idx_reg == CHW'(CH - 1);
  assign mac_last    = (state_reg == ST_MAC) && last_tap;
  assign mac_final   = mac_last && last_ch;
  assign mode_change = mode_cap_reg != mode_act_reg;

  filter_coef_rom #(.CW(CW), .TAPS(TAPS), .TW(TW)) u_rom (
    .mode (mode_act_reg),
    .tap  (tap_idx_reg),
    .coef (coef)
  );

  assign cur_sample = sample_flat[ch_idx_reg*DW +: DW];
  assign cur_newest = newest_flat[ch_idx_reg*DW +: DW];
  assign prod       = cur_sample * coef;
  assign acc_base   = (tap_idx_reg == '0) ? '0 : acc_reg;
  assign acc_sum    = acc_base + {{TW{prod[PW-1]}}, prod};

  // Round half-up, drop the Q1.(CW-1) fraction, then narrow to DW bits.
  function automatic logic [DW-1:0] to_sample(input logic signed [ACCW-1:0] sum);
    logic signed [ACCW-1:0] shifted;
    shifted = (sum + RND) >>> (CW - 1);
`ifdef FILTER_CORE_SAT_EN
    if (shifted > SAT_MAX)
      to_sample = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN)
      to_sample = SAT_MIN[DW-1:0];
    else
      to_sample = shifted[DW-1:0];
`else
    to_sample = shifted[DW-1:0];
`endif
  endfunction

  always_comb begin
    result = to_sample(acc_sum);
    if (mode_act_reg == MODE_BYP)
      result = cur_newest;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (f_s) state_next = ST_SHIFT;
      ST_SHIFT: state_next = ST_MAC;
      ST_MAC:   if (last_tap && last_ch) state_next = ST_OUT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      tap_idx_reg    <= '0;
      ch_idx_reg     <= '0;
      din_cap_reg    <= '0;
      mode_cap_reg   <= '0;
      mode_act_reg   <= '0;
      acc_reg        <= '0;
      dout_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dout_valid_reg <= 1'b0;
      if (accept) begin
        din_cap_reg  <= din;
        mode_cap_reg <= mode_sel;
      end
      if (state_reg == ST_SHIFT) begin
        mode_act_reg <= mode_cap_reg;
        tap_idx_reg  <= '0;
        ch_idx_reg   <= '0;
      end
      if (state_reg == ST_MAC) begin
        acc_reg     <= acc_sum;
        tap_idx_reg <= tap_idx_reg + 1'b1;
        if (last_tap)
          ch_idx_reg <= ch_idx_reg + 1'b1;
        if (last_tap && last_ch)
          dout_valid_reg <= 1'b1;
      end
      // A dropped strobe outranks a simultaneous clear.
      if (f_s && (state_reg != ST_IDLE))
        overrun_reg <= 1'b1;
      else if (ovr_clr)
        overrun_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [DW-1:0] line_reg [TAPS];
      logic [DW-1:0] dout_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int t = 0; t < TAPS; t++)
            line_reg[t] <= '0;
        end else if (state_reg == ST_SHIFT) begin
          line_reg[0] <= din_cap_reg[gi*DW +: DW];
          for (int t = 1; t < TAPS; t++)
            line_reg[t] <= mode_change ? '0 : line_reg[t-1];
        end
      end

      assign sample_flat[gi*DW +: DW] = line_reg[tap_idx_reg];
      assign newest_flat[gi*DW +: DW] = line_reg[0];
      assign dout[gi*DW +: DW]        = dout_reg;

      // Earlier channels park their result until the last channel finishes.
      if (gi < CH - 1) begin : g_buf
        logic [DW-1:0] res_reg;
        always_ff @(posedge clk) begin
          if (!rst) begin
            res_reg  <= '0;
            dout_reg <= '0;
          end else begin
            if (mac_last && (ch_idx_reg == CHW'(gi)))
              res_reg <= result;
            if (mac_final)
              dout_reg <= res_reg;
          end
        end
      end else begin : g_last
        always_ff @(posedge clk) begin
          if (!rst)
            dout_reg <= '0;
          else if (mac_final)
            dout_reg <= result;
        end
      end
    end
  endgenerate

  assign dout_valid = dout_valid_reg;
  assign busy       = state_reg != ST_IDLE;
  assign overrun    = overrun_reg;
  assign mode_act   = mode_act_reg;

endmodule

// File: tb/tb_filter_core_mc.sv
// Scoreboard bench for filter_core_mc: directed scenarios plus randomized strobes
// checked against a sample-history reference model.
module tb_filter_core_mc;

  localparam int DW     = 16;
  localparam int CW     = 16;
  localparam int TAPS   = 16;
  localparam int CH     = 2;
  localparam int LAT    = CH * TAPS + 2;
  localparam int PERIOD = CH * TAPS + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             f_s = 1'b0;
  logic             ovr_clr = 1'b0;
  logic [1:0]       mode_sel = 2'b00;
  logic [CH*DW-1:0] din = '0;
  logic [CH*DW-1:0] dout;
  logic             dout_valid, busy, overrun;
  logic [1:0]       mode_act;

  filter_core_mc #(.DW(DW), .CW(CW), .TAPS(TAPS), .CH(CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .f_s        (f_s),
    .mode_sel   (mode_sel),
    .din        (din),
    .ovr_clr    (ovr_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun),
    .mode_act   (mode_act)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CH*DW-1:0] data;
    int               cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: per-channel sample history (index 0 = newest) and active mode.
  int hist [CH][TAPS];
  int cur_mode = 0;
  int next_free = 0;
  bit exp_ovr = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  function automatic int model_coef(input int mode, input int i);
    int unit;
    int m;
    unit = (1 << (CW - 1)) / TAPS;
    m = (i < TAPS - 1 - i) ? i : TAPS - 1 - i;
    case (mode)
      1: return unit;
      2: return (i == 0) ? (1 << (CW - 1)) - 1 - unit : -unit;
      3: return (m % 2 == 1) ? -unit : unit;
      default: return 0;
    endcase
  endfunction

  function automatic logic [CH*DW-1:0] pack2(input int a0, input int a1);
    logic [DW-1:0] l0;
    logic [DW-1:0] l1;
    l0 = a0[DW-1:0];
    l1 = a1[DW-1:0];
    return {l1, l0};
  endfunction

  task automatic model_clear();
    foreach (hist[c, t]) hist[c][t] = 0;
  endtask

  task automatic model_step(input logic [CH*DW-1:0] d, input int mode, output logic [CH*DW-1:0] y);
    longint acc;
    y = '0;
    if (mode != cur_mode) model_clear();
    cur_mode = mode;
    for (int c = 0; c < CH; c++) begin
      for (int t = TAPS - 1; t > 0; t--) hist[c][t] = hist[c][t-1];
      hist[c][0] = $signed(d[c*DW +: DW]);
      if (mode == 0) begin
        y[c*DW +: DW] = d[c*DW +: DW];
      end else begin
        acc = 0;
        for (int t = 0; t < TAPS; t++) acc += longint'(hist[c][t]) * model_coef(mode, t);
        acc = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
`ifdef FILTER_CORE_SAT_EN
        if (acc > (longint'(1) << (DW - 1)) - 1) acc = (longint'(1) << (DW - 1)) - 1;
        if (acc < -(longint'(1) << (DW - 1))) acc = -(longint'(1) << (DW - 1));
`endif
        y[c*DW +: DW] = acc[DW-1:0];
      end
    end
  endtask

  // Drives a one-cycle strobe; the model decides whether the DUT should accept it.
  task automatic strobe(input logic [CH*DW-1:0] d, input int mode, input bit clr);
    exp_t e;
    logic [CH*DW-1:0] y;
    @(posedge clk); #1;
    f_s = 1'b1;
    din = d;
    mode_sel = 2'(mode);
    ovr_clr = clr;
    if (cyc >= next_free) begin
      model_step(d, mode, y);
      e.data = y;
      e.cyc = cyc;
      exp_q.push_back(e);
      next_free = cyc + PERIOD;
      if (clr) exp_ovr = 0;
    end else begin
      exp_ovr = 1;
    end
    @(posedge clk); #1;
    f_s = 1'b0;
    ovr_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL idle_timeout: %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_until(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_clear();
    cur_mode = 0;
    next_free = 0;
    exp_ovr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    f_s = 1'b0;
    ovr_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_mode_act"}, mode_act, 0);
  endtask

  // Monitor: every dout_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && dout_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: dout_valid with dout 0x%0h at cycle %0d, required none", dout, cyc);
      end else begin
        e = exp_q.pop_front();
        check("sb_dout", dout, e.data);
        check("sb_latency", cyc - e.cyc, LAT);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int v;
    int base;
    int mode;
    int gap;
    logic [CH*DW-1:0] d;

    do_reset();
    check_reset_state("reset");

    // Bypass: exact newest sample after full latency.
    strobe(32'hFEDC_1234, 0, 0);
    wait_idle();
    check("bypass_dout", dout, 32'hFEDC_1234);

    // LPF DC ramp-up: first output 1/16 of the input, 16th output the full input.
    for (int i = 0; i < 16; i++) begin
      strobe(pack2(1600, -1600), 1, 0);
      wait_idle();
      if (i == 0) check("lpf_first", dout, pack2(100, -100));
      if (i == 15) check("lpf_settled", dout, pack2(1600, -1600));
    end
    check("lpf_mode_act", mode_act, 1);

    // HPF rejects DC once the history is full.
    for (int i = 0; i < 32; i++) begin
      strobe(pack2(8000, 0), 2, 0);
      wait_idle();
    end
    v = $signed(dout[DW-1:0]);
    checks++;
    if (v > 1 || v < -1) begin
      errors++;
      $display("FAIL hpf_dc_reject: got %0d, required -1..1", v);
    end

    // Overrun: second strobe 10 cycles after the first is dropped.
    strobe(pack2(1234, -4321), 2, 0);
    repeat (8) begin @(posedge clk); #1; end
    check("ovr_before", overrun, 0);
    check("busy_mid", busy, 1);
    strobe(pack2(7, 7), 2, 0);
    check("ovr_set", overrun, 1);
    wait_idle();
    check("ovr_held", overrun, 1);
    @(posedge clk); #1; ovr_clr = 1'b1;
    @(posedge clk); #1; ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    strobe(pack2(100, 200), 2, 0);
    repeat (4) begin @(posedge clk); #1; end
    strobe(pack2(5, 5), 2, 1);
    check("ovr_set_wins", overrun, 1);
    wait_idle();
    @(posedge clk); #1; ovr_clr = 1'b1;
    @(posedge clk); #1; ovr_clr = 1'b0;
    exp_ovr = 0;

    // Mode switches flush the history.
    for (int i = 0; i < 5; i++) begin
      strobe(pack2(1600, 1600), 1, 0);
      wait_idle();
    end
    strobe(32'h0ABC_0123, 0, 0);
    wait_idle();
    check("switch_bypass", dout, 32'h0ABC_0123);
    strobe(pack2(1600, -1600), 1, 0);
    wait_idle();
    check("switch_lpf_flushed", dout, pack2(100, -100));

    // Reset in the middle of MAC: no result, everything back to zero.
    strobe(pack2(3000, 3000), 1, 0);
    repeat (19) begin @(posedge clk); #1; end
    base = n_valid;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    check_reset_state("midreset");
    repeat (40) begin @(posedge clk); #1; end
    check("midreset_no_valid", n_valid - base, 0);

    // Randomized strobes, including minimum spacing and dropped strobes.
    mode = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) mode = $urandom_range(0, 3);
      d = $urandom;
      gap = $urandom_range(0, 3);
      wait_until(next_free - 1 + gap);
      strobe(d, mode, 0);
      if ($urandom_range(0, 5) == 0) begin
        wait_until(cyc + $urandom_range(1, 25));
        strobe($urandom, $urandom_range(0, 3), 0);
      end
    end
    wait_idle();
    check("rand_overrun", overrun, longint'(exp_ovr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_core_mc.md
FILTER_CORE_MC -- requirements
Module: filter_core_mc

Interface
REQ-001 SHALL have parameter DW, default 16, sample width per channel (signed).
REQ-002 SHALL have parameter CW, default 16, coefficient width (signed Q1.(CW-1)).
REQ-003 SHALL have parameter TAPS, default 16, FIR taps per channel (power of 2, 4..64).
REQ-004 SHALL have parameter CH, default 2, channel count (1..8).
REQ-005 SHALL use one clock; reset is synchronous and active-low: port clk input 1, rising-edge clock.
REQ-006 Port rst input 1: synchronous active-low reset.
REQ-007 Port f_s input 1: sample strobe, one-cycle pulse.
REQ-008 Port mode_sel input 2: 00 bypass, 01 LPF, 10 HPF, 11 BPF.
REQ-009 Port din input CH*DW: channel k at bits [k*DW +: DW].
REQ-010 Port ovr_clr input 1: clears overrun.
REQ-011 Port dout output CH*DW: filtered samples, same packing as din.
REQ-012 Port dout_valid output 1: one-cycle pulse when dout updates.
REQ-013 Port busy output 1: high whenever FSM not IDLE.
REQ-014 Port overrun output 1: sticky, strobe dropped.
REQ-015 Port mode_act output 2: mode currently applied.

Function
REQ-016 FSM states IDLE, SHIFT, MAC, OUT; IDLE->SHIFT on f_s; SHIFT->MAC after 1 cycle; MAC->OUT after CH*TAPS cycles; OUT->IDLE after 1 cycle.
REQ-017 din and mode_sel SHALL be captured on the f_s cycle in IDLE only.
REQ-018 SHIFT: each channel delay line shifts by one, newest tap = captured din.
REQ-019 If captured mode_sel != mode_act, SHIFT SHALL zero all older taps of every channel and update mode_act.
REQ-020 MAC: single shared multiplier, one tap per cycle, channel 0 taps 0..TAPS-1 first, then channel 1, etc.
REQ-021 Accumulator width DW+CW+log2(TAPS); cleared at start of each channel.
REQ-022 Result = accumulator arithmetically right-shifted by CW-1, rounded half-up (add 2^(CW-2) before shift).
REQ-023 Bypass mode: dout channel SHALL equal newest tap exactly, still with full latency.
REQ-024 dout and dout_valid SHALL update in OUT: f_s at cycle 0 -> dout_valid at cycle CH*TAPS+2.
REQ-025 dout SHALL hold between updates.
REQ-026 f_s while busy: sample dropped, overrun set next cycle, operation in progress unaffected.
REQ-027 ovr_clr and a simultaneous overrun event: set wins.
REQ-028 Minimum accepted sample period CH*TAPS+3 cycles.

Reset
REQ-029 rst low at a clock edge: FSM IDLE, dout 0, dout_valid 0, busy 0, overrun 0, mode_act 00, all delay lines and accumulator 0.
REQ-030 Reset mid-operation SHALL abort without emitting dout_valid.

Configuration
REQ-031 With FILTER_CORE_SAT_EN defined, results exceeding DW SHALL saturate to +2^(DW-1)-1 / -2^(DW-1).
REQ-032 Without FILTER_CORE_SAT_EN, results SHALL be truncated to the low DW bits (two's-complement wrap).

Structure
REQ-033 Package filter_core_pkg SHALL hold mode encodings, FSM state type, and per-mode coefficient tables.
REQ-034 LPF table: all taps 2^(CW-1)/TAPS; HPF: tap0 = 2^(CW-1)-1-2^(CW-1)/TAPS, others -2^(CW-1)/TAPS; BPF: package-defined symmetric table.
REQ-035 Sub-module filter_coef_rom SHALL return coefficient for (mode, tap index) combinationally.

Verification (DW=16, CW=16, TAPS=16, CH=2)
REQ-036 Bypass, f_s with din ch0=0x1234, ch1=0xFEDC -> dout_valid at cycle 34, dout ch0=0x1234, ch1=0xFEDC.
REQ-037 LPF, 16 strobes ch0=1600 DC, ch1=-1600 -> 16th output ch0=1600, ch1=-1600; 1st output 100, -100.
REQ-038 HPF, 32 strobes ch0=8000 DC -> final ch0 output within +/-1 of 0.
REQ-039 LPF with ch0=0x7FFF DC, coefficients forced to 0x7FFF by test override -> with FILTER_CORE_SAT_EN dout=0x7FFF; without, wrapped value per REQ-032.
REQ-040 f_s at cycles 0 and 10 -> only one dout_valid (cycle 34), overrun=1 at cycle 11, held until ovr_clr.
REQ-041 Mode switch LPF->bypass after 5 strobes of 1600 -> first bypass output = new din, delay lines zero; rst low at cycle 20 of a MAC -> no dout_valid, all outputs 0.
